bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Two-master arbiter for the peripheral bus (GPU/UART/PS2 decoder). Serialises requests from
//  master 0 (CPU) and master 1 (DMA/debug) onto the single bus master port.
//  Each transaction is held until the slave acks. A watchdog terminates any transaction the
//  slave leaves unacknowledged (e.g. an unmapped address) and flags it.
// PARAMETERS
//  FIXED_PRIO      0    0 = round-robin between masters; 1 = master 0 always wins ties
//  CNT_W           8    width of the watchdog counter
//  TIMEOUT_CYCLES  255  BUSY cycles without ack before forced termination; must be >= 1 and <= 2^CNT_W-1
// PORTS
//  clk             in   1   system clock, rising edge
//  rst             in   1   asynchronous reset, active-high
//  m0_addr_i       in   32  master 0 address
//  m0_data_i       in   32  master 0 write data
//  m0_data_o       out  32  master 0 read data
//  m0_sel_i        in   2   master 0 size select
//  m0_rd_i         in   1   master 0 read request, held until ack
//  m0_we_i         in   1   master 0 write request, held until ack
//  m0_ack_o        out  1   master 0 ack
//  m1_*            same set and meaning for master 1
//  s_addr_o        out  32  bus address
//  s_data_o        out  32  bus write data
//  s_data_i        in   32  bus read data
//  s_sel_o         out  2   bus size select
//  s_rd_o          out  1   bus read strobe
//  s_we_o          out  1   bus write strobe
//  s_ack_i         in   1   bus ack, may be combinational from s_rd_o/s_we_o
//  grant_o         out  2   one-hot current owner; 00 when idle
//  timeout_o       out  1   one-cycle pulse on watchdog termination
//  timeout_addr_o  out  32  address of the last timed-out transaction; holds until the next timeout
// BEHAVIOUR
//  Reset (async)
//   - State -> IDLE; counter = 0; last_owner = 1; timeout_addr_o = 0.
//   - All outputs = 0 while rst is high and in the first IDLE cycle.
//   - Reset during BUSY abandons the transaction silently: no ack, no timeout pulse.
//  Request
//   - reqN = mN_rd_i | mN_we_i.
//  IDLE
//   - s_* outputs all 0; grant_o = 00; both mN_ack_o = 0.
//   - If any reqN is high: next state BUSY; owner registered at the clock edge.
//   - Arbitration, both requesting:
//       FIXED_PRIO = 1 -> m0.
//       FIXED_PRIO = 0 -> the master != last_owner.
//   - Arbitration, one requesting: that master.
//  BUSY (owner k)
//   - s_addr/data/sel/rd/we_o = mk_* inputs, combinational pass-through.
//   - grant_o[k] = 1.
//   - mk_data_o = s_data_i; mk_ack_o = s_ack_i.
//   - Non-owner: data_o = 0, ack_o = 0.
//   - Counter increments each BUSY cycle without ack.
//  Leaving BUSY
//   - s_ack_i = 1: next state IDLE; last_owner = k; counter = 0.
//   - No ack and counter == TIMEOUT_CYCLES-1:
//       mk_ack_o = 1 and mk_data_o = 32'h0 this cycle; s_rd_o/s_we_o still driven.
//       timeout_o = 1 (registered, next cycle); timeout_addr_o <= mk_addr_i.
//       next state IDLE; last_owner = k; counter = 0.
//   - Ack and timeout in the same cycle: ack wins; no timeout_o.
//  Latency
//   - Request in IDLE cycle N -> strobe on bus in cycle N+1.
//   - Minimum 2 cycles per transaction: one IDLE gap + one BUSY.
//   - The IDLE gap lets the acked master drop its request before re-arbitration.
//  Master behaviour
//   - The owner dropping its request mid-BUSY is illegal.
//   - The arbiter still waits for ack or timeout.
//  Round-robin fairness
//   - Continuous requests from both masters alternate strictly: m0, m1, m0, ...
// TESTING
//  1. Reset; m0 read 0xFFFF_FC00; slave acks in the 1st BUSY cycle with 0x12
//     -> s_rd_o rises 1 cycle after request; m0_data_o = 0x12 with m0_ack_o; m1_ack_o stays 0.
//  2. m0 and m1 both request continuously, FIXED_PRIO = 0
//     -> grants m0, m1, m0, m1 with one IDLE cycle between each.
//  3. Same as 2 with FIXED_PRIO = 1 -> m0 granted every time; m1 granted only once m0 drops.
//  4. m1 write to 0x0000_1000, slave never acks, TIMEOUT_CYCLES = 4
//     -> m1_ack_o high in the 4th BUSY cycle with data 0; timeout_o pulses next cycle;
//        timeout_addr_o = 0x0000_1000.
//  5. Ack arrives on exactly the timeout cycle -> normal ack, timeout_o stays 0, timeout_addr_o unchanged.
//  6. rst asserted mid-BUSY with s_ack_i = 0 -> all outputs 0 immediately;
//     after release the first tie goes to m0.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Peripheral bus bundle: two requesting masters on one side, the shared bus plus status on the other.
// The arbiter takes the slave modport; whatever drives the masters and models the bus takes master.
interface bus_arbiter_if;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
  logic [1:0]  m0_sel_i;
  logic        m0_rd_i, m0_we_i, m0_ack_o;
  logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
  logic [1:0]  m1_sel_i;
  logic        m1_rd_i, m1_we_i, m1_ack_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic [1:0]  s_sel_o;
  logic        s_rd_o, s_we_o, s_ack_i;
  logic [1:0]  grant_o;
  logic        timeout_o;
  logic [31:0] timeout_addr_o;

  modport slave (
    input  m0_addr_i, m0_data_i, m0_sel_i, m0_rd_i, m0_we_i,
    output m0_data_o, m0_ack_o,
    input  m1_addr_i, m1_data_i, m1_sel_i, m1_rd_i, m1_we_i,
    output m1_data_o, m1_ack_o,
    output s_addr_o, s_data_o, s_sel_o, s_rd_o, s_we_o,
    input  s_data_i, s_ack_i,
    output grant_o, timeout_o, timeout_addr_o
  );

  modport master (
    output m0_addr_i, m0_data_i, m0_sel_i, m0_rd_i, m0_we_i,
    input  m0_data_o, m0_ack_o,
    output m1_addr_i, m1_data_i, m1_sel_i, m1_rd_i, m1_we_i,
    input  m1_data_o, m1_ack_o,
    input  s_addr_o, s_data_o, s_sel_o, s_rd_o, s_we_o,
    output s_data_i, s_ack_i,
    input  grant_o, timeout_o, timeout_addr_o
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with watchdog; strobe one cycle after request, >= 2 cycles per transfer.
// Requests are held until ack (or watchdog ack); the IDLE gap lets the acked master drop its request.
module bus_arbiter #(
  parameter bit FIXED_PRIO     = 1'b0,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic         clk,
  input logic         rst,
  bus_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      timeout_addr_q, timeout_addr_d;

  logic        req0, req1, busy, expire;
  logic [31:0] own_addr, own_data;
  logic [1:0]  own_sel;
  logic        own_rd, own_we;

  assign req0 = bus.m0_rd_i | bus.m0_we_i;
  assign req1 = bus.m1_rd_i | bus.m1_we_i;
  assign busy = (state_q == BUSY);
  // Ack has priority over the watchdog when both land on the same cycle.
  assign expire = busy & ~bus.s_ack_i & (cnt_q == CNT_LAST);

  assign own_addr = owner_q ? bus.m1_addr_i : bus.m0_addr_i;
  assign own_data = owner_q ? bus.m1_data_i : bus.m0_data_i;
  assign own_sel  = owner_q ? bus.m1_sel_i  : bus.m0_sel_i;
  assign own_rd   = owner_q ? bus.m1_rd_i   : bus.m0_rd_i;
  assign own_we   = owner_q ? bus.m1_we_i   : bus.m0_we_i;

  assign bus.s_addr_o = busy ? own_addr : 32'h0;
  assign bus.s_data_o = busy ? own_data : 32'h0;
  assign bus.s_sel_o  = busy ? own_sel  : 2'b00;
  assign bus.s_rd_o   = busy & own_rd;
  assign bus.s_we_o   = busy & own_we;
  assign bus.grant_o  = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

  assign bus.m0_ack_o  = busy & ~owner_q & (bus.s_ack_i | expire);
  assign bus.m1_ack_o  = busy &  owner_q & (bus.s_ack_i | expire);
  assign bus.m0_data_o = (busy & ~owner_q & ~expire) ? bus.s_data_i : 32'h0;
  assign bus.m1_data_o = (busy &  owner_q & ~expire) ? bus.s_data_i : 32'h0;

  assign bus.timeout_o      = timeout_q;
  assign bus.timeout_addr_o = timeout_addr_q;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    cnt_d          = cnt_q;
    timeout_d      = 1'b0;
    timeout_addr_d = timeout_addr_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = BUSY;
          cnt_d   = '0;
          if (req0 & req1) owner_d = FIXED_PRIO ? 1'b0 : ~last_owner_q;
          else             owner_d = req1;
        end
      end
      BUSY: begin
        if (bus.s_ack_i | expire) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          cnt_d        = '0;
          if (expire) begin
            timeout_d      = 1'b1;
            timeout_addr_d = own_addr;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      last_owner_q   <= 1'b1;
      cnt_q          <= '0;
      timeout_q      <= 1'b0;
      timeout_addr_q <= 32'h0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_owner_q   <= last_owner_d;
      cnt_q          <= cnt_d;
      timeout_q      <= timeout_d;
      timeout_addr_q <= timeout_addr_d;
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter (both watchdog 4) with shared directed stimulus
// and checks every cycle against a transaction-level model, plus literal expectations.
module tb_bus_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] m0_addr = 0, m0_wdat = 0, m1_addr = 0, m1_wdat = 0, s_din = 0;
  logic [1:0]  m0_sel = 2'b10, m1_sel = 2'b01;
  logic        m0_rd = 0, m0_we = 0, m1_rd = 0, m1_we = 0, s_ack = 0;

  bus_arbiter_if ifa ();
  bus_arbiter_if ifb ();

  assign ifa.m0_addr_i = m0_addr; assign ifb.m0_addr_i = m0_addr;
  assign ifa.m0_data_i = m0_wdat; assign ifb.m0_data_i = m0_wdat;
  assign ifa.m0_sel_i  = m0_sel;  assign ifb.m0_sel_i  = m0_sel;
  assign ifa.m0_rd_i   = m0_rd;   assign ifb.m0_rd_i   = m0_rd;
  assign ifa.m0_we_i   = m0_we;   assign ifb.m0_we_i   = m0_we;
  assign ifa.m1_addr_i = m1_addr; assign ifb.m1_addr_i = m1_addr;
  assign ifa.m1_data_i = m1_wdat; assign ifb.m1_data_i = m1_wdat;
  assign ifa.m1_sel_i  = m1_sel;  assign ifb.m1_sel_i  = m1_sel;
  assign ifa.m1_rd_i   = m1_rd;   assign ifb.m1_rd_i   = m1_rd;
  assign ifa.m1_we_i   = m1_we;   assign ifb.m1_we_i   = m1_we;
  assign ifa.s_data_i  = s_din;   assign ifb.s_data_i  = s_din;
  assign ifa.s_ack_i   = s_ack;   assign ifb.s_ack_i   = s_ack;

  bus_arbiter #(.FIXED_PRIO(1'b0), .CNT_W(8), .TIMEOUT_CYCLES(TO)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  bus_arbiter #(.FIXED_PRIO(1'b1), .CNT_W(8), .TIMEOUT_CYCLES(TO)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct packed {
    logic [31:0] m0_data; logic m0_ack;
    logic [31:0] m1_data; logic m1_ack;
    logic [31:0] s_addr;  logic [31:0] s_data; logic [1:0] s_sel;
    logic        s_rd;    logic s_we;    logic [1:0] grant;
    logic        timeout; logic [31:0] timeout_addr;
  } out_t;

  out_t act [2];
  assign act[0] = {ifa.m0_data_o, ifa.m0_ack_o, ifa.m1_data_o, ifa.m1_ack_o, ifa.s_addr_o, ifa.s_data_o,
                   ifa.s_sel_o, ifa.s_rd_o, ifa.s_we_o, ifa.grant_o, ifa.timeout_o, ifa.timeout_addr_o};
  assign act[1] = {ifb.m0_data_o, ifb.m0_ack_o, ifb.m1_data_o, ifb.m1_ack_o, ifb.s_addr_o, ifb.s_data_o,
                   ifb.s_sel_o, ifb.s_rd_o, ifb.s_we_o, ifb.grant_o, ifb.timeout_o, ifb.timeout_addr_o};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Transaction-level model: owner -1 means no transaction in flight.
  bit          fixed [2] = '{1'b0, 1'b1};
  int          m_owner [2] = '{-1, -1};
  int          m_waited [2] = '{0, 0};
  int          m_last [2] = '{1, 1};
  bit          m_pulse [2] = '{1'b0, 1'b0};
  logic [31:0] m_to_addr [2] = '{32'h0, 32'h0};

  function automatic bit forced(int i);
    return (m_owner[i] >= 0) && !s_ack && (m_waited[i] + 1 == TO);
  endfunction

  function automatic out_t model_out(int i);
    out_t e = '0;
    bit f;
    if (rst) return e;
    e.timeout      = m_pulse[i];
    e.timeout_addr = m_to_addr[i];
    if (m_owner[i] < 0) return e;
    f = forced(i);
    if (m_owner[i] == 0) begin
      e.s_addr = m0_addr; e.s_data = m0_wdat; e.s_sel = m0_sel; e.s_rd = m0_rd; e.s_we = m0_we;
      e.grant = 2'b01; e.m0_ack = s_ack | f; e.m0_data = f ? 32'h0 : s_din;
    end else begin
      e.s_addr = m1_addr; e.s_data = m1_wdat; e.s_sel = m1_sel; e.s_rd = m1_rd; e.s_we = m1_we;
      e.grant = 2'b10; e.m1_ack = s_ack | f; e.m1_data = f ? 32'h0 : s_din;
    end
    return e;
  endfunction

  logic [1:0] grants [2][$];
  bit         record = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      out_t e;
      string p;
      e = model_out(i);
      p = (i == 0) ? "rr" : "fp";
      chk({p, ".m0_data"}, act[i].m0_data, e.m0_data);
      chk({p, ".m0_ack"}, 32'(act[i].m0_ack), 32'(e.m0_ack));
      chk({p, ".m1_data"}, act[i].m1_data, e.m1_data);
      chk({p, ".m1_ack"}, 32'(act[i].m1_ack), 32'(e.m1_ack));
      chk({p, ".s_addr"}, act[i].s_addr, e.s_addr);
      chk({p, ".s_data"}, act[i].s_data, e.s_data);
      chk({p, ".s_sel"}, 32'(act[i].s_sel), 32'(e.s_sel));
      chk({p, ".s_rd"}, 32'(act[i].s_rd), 32'(e.s_rd));
      chk({p, ".s_we"}, 32'(act[i].s_we), 32'(e.s_we));
      chk({p, ".grant"}, 32'(act[i].grant), 32'(e.grant));
      chk({p, ".timeout"}, 32'(act[i].timeout), 32'(e.timeout));
      chk({p, ".timeout_addr"}, act[i].timeout_addr, e.timeout_addr);
      if (record && act[i].grant != 2'b00) grants[i].push_back(act[i].grant);
    end
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_owner[i] = -1; m_waited[i] = 0; m_last[i] = 1; m_pulse[i] = 0; m_to_addr[i] = 0;
      end else if (m_owner[i] < 0) begin
        bit r0, r1;
        r0 = m0_rd | m0_we;
        r1 = m1_rd | m1_we;
        m_pulse[i] = 0;
        if (r0 || r1) begin
          m_waited[i] = 0;
          if (r0 && r1) m_owner[i] = fixed[i] ? 0 : 1 - m_last[i];
          else          m_owner[i] = r0 ? 0 : 1;
        end
      end else begin
        bit f;
        f = forced(i);
        m_pulse[i] = f;
        if (s_ack || f) begin
          if (f) m_to_addr[i] = (m_owner[i] == 0) ? m0_addr : m1_addr;
          m_last[i]  = m_owner[i];
          m_owner[i] = -1;
        end else begin
          m_waited[i]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_rr [5];
    logic [1:0] exp_fp [5];
    exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
    exp_fp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    tick(); tick();
    // Read from m0, acked in first BUSY cycle.
    rst = 0; m0_addr = 32'hFFFF_FC00; m0_rd = 1; s_ack = 1; s_din = 32'h12;
    #1;
    chk("t1.idle_rd", 32'(ifa.s_rd_o), 32'd0);
    chk("t1.idle_grant", 32'(ifa.grant_o), 32'd0);
    tick(); #1;
    chk("t1.s_rd", 32'(ifa.s_rd_o), 32'd1);
    chk("t1.s_addr", ifa.s_addr_o, 32'hFFFF_FC00);
    chk("t1.m0_ack", 32'(ifa.m0_ack_o), 32'd1);
    chk("t1.m0_data", ifa.m0_data_o, 32'h12);
    chk("t1.m1_ack", 32'(ifa.m1_ack_o), 32'd0);

    // m1 write to an unmapped address, never acked.
    tick();
    m0_rd = 0; s_ack = 0; s_din = 32'hDEAD_BEEF;
    m1_addr = 32'h0000_1000; m1_wdat = 32'hA5A5_0001; m1_we = 1;
    for (int n = 1; n <= TO; n++) begin
      tick(); #1;
      chk("t4.m1_ack", 32'(ifb.m1_ack_o), (n == TO) ? 32'd1 : 32'd0);
      if (n == TO) begin
        chk("t4.m1_data", ifb.m1_data_o, 32'h0);
        chk("t4.s_we", 32'(ifb.s_we_o), 32'd1);
        chk("t4.no_pulse_yet", 32'(ifb.timeout_o), 32'd0);
      end
    end
    tick();
    m1_we = 0;
    #1;
    chk("t4.timeout", 32'(ifb.timeout_o), 32'd1);
    chk("t4.timeout_addr", ifb.timeout_addr_o, 32'h0000_1000);
    tick(); #1;
    chk("t4.pulse_end", 32'(ifb.timeout_o), 32'd0);
    chk("t4.addr_hold", ifb.timeout_addr_o, 32'h0000_1000);

    // Ack on exactly the watchdog cycle.
    m0_addr = 32'h0000_2000; m0_wdat = 32'h77; m0_we = 1; s_din = 32'h55;
    tick(); tick(); tick(); tick();
    s_ack = 1;
    #1;
    chk("t5.m0_ack", 32'(ifa.m0_ack_o), 32'd1);
    chk("t5.m0_data", ifa.m0_data_o, 32'h55);
    tick();
    m0_we = 0; s_ack = 0;
    #1;
    chk("t5.no_timeout", 32'(ifa.timeout_o), 32'd0);
    chk("t5.addr_kept", ifa.timeout_addr_o, 32'h0000_1000);

    // Reset in the middle of a stalled transaction.
    m1_addr = 32'h0000_3000; m1_rd = 1;
    tick(); tick();
    rst = 1;
    #1;
    chk("t6.grant", 32'(ifa.grant_o), 32'd0);
    chk("t6.s_rd", 32'(ifa.s_rd_o), 32'd0);
    chk("t6.m1_ack", 32'(ifa.m1_ack_o), 32'd0);
    chk("t6.timeout_addr", ifa.timeout_addr_o, 32'd0);
    tick();

    // Both masters request continuously after reset release.
    rst = 0; m0_addr = 32'h0000_4000; m0_rd = 1; s_ack = 1; s_din = 32'h99;
    grants[0].delete(); grants[1].delete();
    record = 1;
    for (int n = 1; n <= 8; n++) tick();
    m0_rd = 0;
    tick(); tick();
    m1_rd = 0; s_ack = 0;
    tick(); tick();
    record = 0;

    chk("t2.rr_count", 32'(grants[0].size()), 32'd5);
    chk("t3.fp_count", 32'(grants[1].size()), 32'd5);
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("t2.rr_grant%0d", n), (grants[0].size() > n) ? 32'(grants[0][n]) : 32'hX, 32'(exp_rr[n]));
      chk($sformatf("t3.fp_grant%0d", n), (grants[1].size() > n) ? 32'(grants[1][n]) : 32'hX, 32'(exp_fp[n]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
